// File: rtl/fifo_16x4096x128_pkg.sv
// Shared width, depth and threshold constants for the 16-bit-in / 128-bit-out FIFO.
package fifo_16x4096x128_pkg;

    localparam int unsigned DEF_WR_DEPTH_WIDTH   = 14;
    localparam int unsigned DEF_WR_DATA_WIDTH    = 16;
    localparam int unsigned DEF_RD_DEPTH_WIDTH   = 11;
    localparam int unsigned DEF_RD_DATA_WIDTH    = 128;
    localparam int unsigned DEF_ALMOST_FULL_NUM  = 508;
    localparam int unsigned DEF_ALMOST_EMPTY_NUM = 4;

    localparam int unsigned DEF_LANES          = DEF_RD_DATA_WIDTH / DEF_WR_DATA_WIDTH;
    localparam int unsigned DEF_WR_LEVEL_WIDTH = DEF_WR_DEPTH_WIDTH + 1;
    localparam int unsigned DEF_RD_LEVEL_WIDTH = DEF_RD_DEPTH_WIDTH + 1;

endpackage

// File: rtl/fifo_16x4096x128_if.sv
// Write/read handshake, data and status bundle of the width-converting FIFO.
interface fifo_16x4096x128_if;
    import fifo_16x4096x128_pkg::*;

    logic [DEF_WR_DATA_WIDTH-1:0]  wr_data;
    logic                          wr_en;
    logic                          wr_full;
    logic [DEF_WR_LEVEL_WIDTH-1:0] wr_water_level;
    logic                          almost_full;
    logic [DEF_RD_DATA_WIDTH-1:0]  rd_data;
    logic                          rd_en;
    logic                          rd_empty;
    logic [DEF_RD_LEVEL_WIDTH-1:0] rd_water_level;
    logic                          almost_empty;

    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_full, wr_water_level, almost_full,
        input  rd_data, rd_empty, rd_water_level, almost_empty
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_full, wr_water_level, almost_full,
        output rd_data, rd_empty, rd_water_level, almost_empty
    );

endinterface

// File: rtl/sdp_ram_2048x128.sv
// Simple dual-port RAM with per-lane write enables and a synchronous, resettable read port.
module sdp_ram_2048x128 #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned LANE_WIDTH = 16,
    parameter int unsigned LANES      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [LANES-1:0]            wr_lane_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [LANES*LANE_WIDTH-1:0] wr_data,
    input  logic                        rd_en,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    output logic [LANES*LANE_WIDTH-1:0] rd_data
);

    localparam int unsigned DATA_WIDTH = LANES * LANE_WIDTH;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (wr_en && wr_lane_en[i]) begin
                mem[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // Output latch clears on reset so rd_data starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_16x4096x128.sv
// Single-clock FIFO packing eight 16-bit writes into one 128-bit read word.
module fifo_16x4096x128
    import fifo_16x4096x128_pkg::*;
#(
    parameter int unsigned WR_DEPTH_WIDTH   = DEF_WR_DEPTH_WIDTH,
    parameter int unsigned WR_DATA_WIDTH    = DEF_WR_DATA_WIDTH,
    parameter int unsigned RD_DEPTH_WIDTH   = DEF_RD_DEPTH_WIDTH,
    parameter int unsigned RD_DATA_WIDTH    = DEF_RD_DATA_WIDTH,
    parameter int unsigned ALMOST_FULL_NUM  = DEF_ALMOST_FULL_NUM,
    parameter int unsigned ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM
) (
    input logic                clk,
    input logic                rst,
    fifo_16x4096x128_if.slave  bus
);

    localparam int unsigned LANES      = RD_DATA_WIDTH / WR_DATA_WIDTH;
    localparam int unsigned LANE_SEL_W = $clog2(LANES);
    localparam int unsigned WR_PTR_W   = WR_DEPTH_WIDTH + 1;
    localparam int unsigned RD_PTR_W   = RD_DEPTH_WIDTH + 1;

    logic                wr_acc_c;
    logic                rd_acc_c;
    logic [LANES-1:0]    wr_lane_en_c;
    logic [WR_PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [RD_PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [WR_PTR_W-1:0] wr_level_q, wr_level_d;
    logic [RD_PTR_W-1:0] rd_level_q, rd_level_d;
    logic                wr_full_q,  wr_full_d;
    logic                almost_full_q,  almost_full_d;
    logic                rd_empty_q, rd_empty_d;
    logic                almost_empty_q, almost_empty_d;

    // Levels come straight from the pointer difference, with the read pointer scaled to write words.
    always_comb begin
        wr_acc_c       = bus.wr_en && !wr_full_q;
        rd_acc_c       = bus.rd_en && !rd_empty_q;
        wr_lane_en_c   = '0;
        if (wr_acc_c) begin
            wr_lane_en_c = LANES'(1) << wr_ptr_q[LANE_SEL_W-1:0];
        end
        wr_ptr_d       = wr_ptr_q + WR_PTR_W'(wr_acc_c);
        rd_ptr_d       = rd_ptr_q + RD_PTR_W'(rd_acc_c);
        wr_level_d     = wr_ptr_d - (WR_PTR_W'(rd_ptr_d) << LANE_SEL_W);
        rd_level_d     = RD_PTR_W'(wr_level_d >> LANE_SEL_W);
        wr_full_d      = (wr_level_d == (WR_PTR_W'(1) << WR_DEPTH_WIDTH));
        almost_full_d  = (wr_level_d >= WR_PTR_W'(ALMOST_FULL_NUM));
        rd_empty_d     = (rd_level_d == '0);
        almost_empty_d = (rd_level_d <= RD_PTR_W'(ALMOST_EMPTY_NUM));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            wr_level_q     <= '0;
            rd_level_q     <= '0;
            wr_full_q      <= 1'b0;
            almost_full_q  <= 1'b0;
            rd_empty_q     <= 1'b1;
            almost_empty_q <= 1'b1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_level_q     <= wr_level_d;
            rd_level_q     <= rd_level_d;
            wr_full_q      <= wr_full_d;
            almost_full_q  <= almost_full_d;
            rd_empty_q     <= rd_empty_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    // Each write lands directly in its lane; a row becomes readable only once all lanes are filled.
    sdp_ram_2048x128 #(
        .ADDR_WIDTH (RD_DEPTH_WIDTH),
        .LANE_WIDTH (WR_DATA_WIDTH),
        .LANES      (LANES)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_acc_c),
        .wr_lane_en (wr_lane_en_c),
        .wr_addr    (wr_ptr_q[WR_DEPTH_WIDTH-1:LANE_SEL_W]),
        .wr_data    ({LANES{bus.wr_data}}),
        .rd_en      (rd_acc_c),
        .rd_addr    (rd_ptr_q[RD_DEPTH_WIDTH-1:0]),
        .rd_data    (bus.rd_data)
    );

    assign bus.wr_full        = wr_full_q;
    assign bus.wr_water_level = wr_level_q;
    assign bus.almost_full    = almost_full_q;
    assign bus.rd_empty       = rd_empty_q;
    assign bus.rd_water_level = rd_level_q;
    assign bus.almost_empty   = almost_empty_q;

endmodule

// File: tb/tb_fifo_16x4096x128.sv
// Randomized bench for fifo_16x4096x128 against a queue-of-words reference model.
module tb_fifo_16x4096x128;

    logic clk = 1'b0;
    logic rst;

    fifo_16x4096x128_if bus ();

    fifo_16x4096x128 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [15:0]  mq[$];
    logic [127:0] m_rd;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int unsigned sz;
        sz = mq.size();
        check_eq("wr_full",        bus.wr_full,        128'(sz == 16384));
        check_eq("wr_level",       bus.wr_water_level, 128'(sz));
        check_eq("almost_full",    bus.almost_full,    128'(sz >= 508));
        check_eq("rd_empty",       bus.rd_empty,       128'(sz / 8 == 0));
        check_eq("rd_level",       bus.rd_water_level, 128'(sz / 8));
        check_eq("almost_empty",   bus.almost_empty,   128'(sz / 8 <= 4));
        check_eq("rd_data",        bus.rd_data,        m_rd);
    endtask

    // One clock: apply inputs, update the model from its pre-edge state, then compare.
    task automatic tick(input logic w, input logic [15:0] d, input logic r);
        logic wa, ra;
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_rd = '0;
        end else begin
            wa = w && (mq.size() < 16384);
            ra = r && (mq.size() >= 8);
            if (ra) begin
                for (int k = 0; k < 8; k++) m_rd[k*16 +: 16] = mq.pop_front();
            end
            if (wa) mq.push_back(d);
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b1, 16'($urandom), 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;
        m_rd        = '0;
        #2;
        do_reset();

        // Fill with descending data, then one ignored write.
        for (int i = 0; i < 16384; i++) tick(1'b1, 16'(32'hFFFF - i), 1'b0);
        check_eq("full_flag",     bus.wr_full,        128'd1);
        check_eq("full_wr_level", bus.wr_water_level, 128'd16384);
        check_eq("full_rd_level", bus.rd_water_level, 128'd2048);
        tick(1'b1, 16'h1234, 1'b0);
        check_eq("full_ignored",  bus.wr_water_level, 128'd16384);

        // Drain everything, then one ignored read.
        tick(1'b0, 16'h0, 1'b1);
        check_eq("first_rd", bus.rd_data, 128'hFFF8_FFF9_FFFA_FFFB_FFFC_FFFD_FFFE_FFFF);
        for (int i = 0; i < 2047; i++) tick(1'b0, 16'h0, 1'b1);
        check_eq("last_rd",   bus.rd_data,  128'hC000_C001_C002_C003_C004_C005_C006_C007);
        check_eq("drained",   bus.rd_empty, 128'd1);
        tick(1'b0, 16'h0, 1'b1);
        check_eq("empty_hold", bus.rd_data, 128'hC000_C001_C002_C003_C004_C005_C006_C007);

        // Partial group stays invisible until the eighth word.
        for (int i = 0; i < 7; i++) tick(1'b1, 16'($urandom), 1'b0);
        check_eq("partial_empty", bus.rd_empty,       128'd1);
        check_eq("partial_level", bus.rd_water_level, 128'd0);
        tick(1'b1, 16'($urandom), 1'b0);
        check_eq("group_empty", bus.rd_empty,       128'd0);
        check_eq("group_level", bus.rd_water_level, 128'd1);

        // Threshold edges.
        for (int i = 0; i < 499; i++) tick(1'b1, 16'($urandom), 1'b0);
        check_eq("af_507", bus.almost_full, 128'd0);
        tick(1'b1, 16'($urandom), 1'b0);
        check_eq("af_508", bus.almost_full, 128'd1);
        for (int i = 0; i < 58; i++) tick(1'b0, 16'h0, 1'b1);
        check_eq("ae_lvl5", bus.rd_water_level, 128'd5);
        check_eq("ae_5",    bus.almost_empty,   128'd0);
        tick(1'b0, 16'h0, 1'b1);
        check_eq("ae_4",    bus.almost_empty,   128'd1);

        // Simultaneous write and read with 80 words stored.
        do_reset();
        for (int i = 0; i < 80; i++) tick(1'b1, 16'(i), 1'b0);
        tick(1'b1, 16'h0050, 1'b1);
        check_eq("sim_level", bus.wr_water_level, 128'd73);
        check_eq("sim_data",  bus.rd_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);

        // Reset mid-operation discards the partial group as well.
        do_reset();
        for (int i = 0; i < 100; i++) tick(1'b1, 16'($urandom), 1'b0);
        do_reset();
        check_eq("rst_level", bus.wr_water_level, 128'd0);
        check_eq("rst_empty", bus.rd_empty,       128'd1);
        check_eq("rst_data",  bus.rd_data,        128'd0);
        for (int i = 0; i < 8; i++) tick(1'b1, 16'(32'h1000 + i), 1'b0);
        tick(1'b0, 16'h0, 1'b1);
        check_eq("post_rst_rd", bus.rd_data, 128'h1007_1006_1005_1004_1003_1002_1001_1000);

        // Random traffic in write-heavy, balanced and read-heavy phases.
        for (int ph = 0; ph < 3; ph++) begin
            int unsigned pw;
            pw = (ph == 0) ? 90 : (ph == 1) ? 50 : 5;
            for (int i = 0; i < 3000; i++) begin
                tick(1'($urandom_range(0, 99) < pw), 16'($urandom),
                     1'($urandom_range(0, 99) < 30));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
